// File: rtl/fifo_axi_w_drain_pkg.sv
// Shared types and constants for the DMA W-channel drain path.
// Contents: W_LEN_WIDTH (default AxLEN width), W_BUF_DEPTH (output skid buffer
// depth), W_OCC_WIDTH (buffer occupancy width), w_state_t (drain FSM states),
// w_beat_cnt_t (beats-per-burst count, one bit wider than AxLEN).
package redma_pkg;

    localparam int unsigned W_LEN_WIDTH = 8;
    localparam int unsigned W_BUF_DEPTH = 2;
    localparam int unsigned W_OCC_WIDTH = $clog2(W_BUF_DEPTH + 1);

    typedef enum logic [0:0] {
        W_IDLE  = 1'b0,
        W_BURST = 1'b1
    } w_state_t;

    // Holds AxLEN+1 without overflow for a full 2^LEN_WIDTH beat burst.
    typedef logic [W_LEN_WIDTH:0] w_beat_cnt_t;

endpackage

// File: rtl/fifo_axi_w_drain_if.sv
// Read port of the DMA data FIFO.
// Signals: read  - pop request from the reader (master)
//          empty - FIFO has no word available
//          data  - FIFO word, valid the cycle after read (registered read)
// Modports: master (the reader), slave (the FIFO).
interface FIFO_READ #(
    parameter int unsigned DATA_WIDTH = 512
);
    logic                  read;
    logic                  empty;
    logic [DATA_WIDTH-1:0] data;

    modport master (output read, input empty, input data);
    modport slave  (input read, output empty, output data);
endinterface

// File: rtl/fifo_axi_w_drain_out_buf.sv
// w_out_buf: 2-entry in-order queue of {data, last} feeding the AXI W channel.
// Ports: clk, rstn (sync, active-low)
//        push, push_data, push_last - enqueue one entry
//        pop                        - dequeue head entry
//        occ                        - number of valid entries (0..2)
//        head_data, head_last       - oldest entry, held until popped
module w_out_buf
    import redma_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 512
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [DATA_WIDTH-1:0]  push_data,
    input  logic                   push_last,
    input  logic                   pop,
    output logic [W_OCC_WIDTH-1:0] occ,
    output logic [DATA_WIDTH-1:0]  head_data,
    output logic                   head_last
);

    localparam int unsigned PTR_W = $clog2(W_BUF_DEPTH);

    logic [DATA_WIDTH-1:0]  mem_data [W_BUF_DEPTH];
    logic [W_BUF_DEPTH-1:0] mem_last;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    // Wide data storage carries no reset; only the control state is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_last <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
        end else begin
            if (push) begin
                mem_last[wr_ptr] <= push_last;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   occ <= occ + W_OCC_WIDTH'(1);
                2'b01:   occ <= occ - W_OCC_WIDTH'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign head_data = mem_data[rd_ptr];
    assign head_last = mem_last[rd_ptr];

endmodule

// File: rtl/fifo_axi_w_drain.sv
// fifo_axi_w_drain: drains the DMA data FIFO into the AXI4 W channel, one burst
// per command, at up to one beat per cycle under back-pressure.
// Ports: clk, rstn (sync, active-low)
//        cmd_valid/cmd_ready/cmd_len - burst command (cmd_len = beats-1)
//        fifo_rd                     - FIFO_READ.master (read, empty, data)
//        m_wdata/m_wstrb/m_wlast/m_wvalid/m_wready - AXI4 W channel
//        beat_cnt (only with REDMA_W_BEAT_CNT_EN) - W handshakes since reset
// Optional feature macro: REDMA_W_BEAT_CNT_EN.
module fifo_axi_w_drain
    import redma_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned LEN_WIDTH  = W_LEN_WIDTH
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    FIFO_READ.master                fifo_rd,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready
`ifdef REDMA_W_BEAT_CNT_EN
    ,
    output logic [31:0]             beat_cnt
`endif
);

    localparam int unsigned CNT_W = LEN_WIDTH + 1;
    localparam int unsigned LVL_W = W_OCC_WIDTH + 1;

    w_state_t               state;
    logic [CNT_W-1:0]       rd_left;
    logic                   inflight;
    logic                   inflight_last;
    logic [W_OCC_WIDTH-1:0] occ;
    logic                   head_last;
    logic                   pop_c;
    logic                   rd_c;
    logic [LVL_W-1:0]       level_c;

    // Entries held or on their way after this cycle's pop; a read needs a free slot.
    assign level_c = LVL_W'(occ) + LVL_W'(inflight) - LVL_W'(pop_c);
    assign rd_c    = rstn && (state == W_BURST) && (rd_left != '0) && !fifo_rd.empty
                     && (level_c < LVL_W'(W_BUF_DEPTH));

    assign fifo_rd.read = rd_c;
    assign cmd_ready    = rstn && (state == W_IDLE);
    assign m_wvalid     = rstn && (occ != '0);
    assign pop_c        = m_wvalid && m_wready;
    assign m_wlast      = m_wvalid && head_last;
    assign m_wstrb      = '1;

    // Burst control: command capture, read countdown, and read-latency tracking.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= W_IDLE;
            rd_left       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= rd_c;
            inflight_last <= rd_c && (rd_left == CNT_W'(1));
            case (state)
                W_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        rd_left <= CNT_W'(cmd_len) + CNT_W'(1);
                        state   <= W_BURST;
                    end
                end
                W_BURST: begin
                    if (rd_c) begin
                        rd_left <= rd_left - CNT_W'(1);
                    end
                    if (pop_c && m_wlast) begin
                        state <= W_IDLE;
                    end
                end
                default: state <= W_IDLE;
            endcase
        end
    end

    // FIFO data lands in the buffer the cycle after its read was issued.
    w_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rstn      (rstn),
        .push      (inflight),
        .push_data (fifo_rd.data),
        .push_last (inflight_last),
        .pop       (pop_c),
        .occ       (occ),
        .head_data (m_wdata),
        .head_last (head_last)
    );

`ifdef REDMA_W_BEAT_CNT_EN
    // Free-running W handshake counter, wraps modulo 2^32.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            beat_cnt <= '0;
        end else if (pop_c) begin
            beat_cnt <= beat_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_axi_w_drain.sv
// Testbench for fifo_axi_w_drain: queue-based beat model, FIFO model, and
// directed bursts (streaming, single beat, stalls, FIFO underrun, 256 beats,
// mid-burst reset).
`timescale 1ns/1ps
module tb_fifo_axi_w_drain;

    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [LW-1:0]   cmd_len = '0;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic            m_wlast;
    logic            m_wvalid;
    logic            m_wready = 1'b0;
`ifdef REDMA_W_BEAT_CNT_EN
    logic [31:0]     beat_cnt;
`endif

    FIFO_READ #(.DATA_WIDTH(DW)) fifo_if ();

    fifo_axi_w_drain #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .fifo_rd   (fifo_if),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wlast   (m_wlast),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready)
`ifdef REDMA_W_BEAT_CNT_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   wr_idx = 0;
    int   rd_idx = 0;
    int   reads_total = 0;
    int   cmd_words_total = 0;
    int   exp_idx = 0;
    int   nbeats = 0;
    int   hs_total = 0;
    int   hs_since_reset = 0;
    int   wr_mode = 0;
    exp_t exp_q[$];
    logic [DW-1:0] beat_dat [1024];
    logic          beat_last[1024];
    int            beat_cyc [1024];

    function automatic logic [DW-1:0] data_of(input int i);
        return DW'(32'hC0DE_0000 + i);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO model: word i holds data_of(i); registered read data.
    assign fifo_if.empty = (rd_idx == wr_idx);
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_if.read) begin
            reads_total <= reads_total + 1;
            if (rd_idx != wr_idx) begin
                fifo_if.data <= data_of(rd_idx);
                rd_idx       <= rd_idx + 1;
            end
        end
    end

    // W ready: always high, or the repeating 1,0,0 pattern.
    always @(posedge clk) begin
        #1;
        m_wready = (wr_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end

    // Per-cycle compare against the expected beat queue and AXI/FIFO rules.
    logic          pv = 1'b0;
    logic          pr = 1'b0;
    logic          pl = 1'b0;
    logic [DW-1:0] pd = '0;
    always @(negedge clk) begin
        exp_t e;
        logic pop;
        pop = m_wvalid && m_wready;
        if (rstn) begin
            if (pv && !pr) begin
                chk("hold_wvalid", 64'(m_wvalid), 64'(1));
                chk("hold_wdata", 64'(m_wdata), 64'(pd));
                chk("hold_wlast", 64'(m_wlast), 64'(pl));
            end
            if (fifo_if.read) begin
                chk("rd_when_empty", 64'(fifo_if.empty), 64'(0));
                chk("rd_beyond_cmd", 64'(reads_total < cmd_words_total), 64'(1));
                chk("rd_no_space", 64'((reads_total - hs_total - (pop ? 1 : 0)) < 2), 64'(1));
            end
`ifdef REDMA_W_BEAT_CNT_EN
            chk("beat_cnt", 64'(beat_cnt), 64'(hs_since_reset));
`endif
            if (m_wvalid) begin
                chk("wstrb", 64'(m_wstrb), 64'({(DW/8){1'b1}}));
            end
            if (pop) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got %0h expected no beat (t=%0t)", m_wdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("wdata", 64'(m_wdata), 64'(e.d));
                    chk("wlast", 64'(m_wlast), 64'(e.l));
                end
                if (nbeats < 1024) begin
                    beat_dat[nbeats]  = m_wdata;
                    beat_last[nbeats] = m_wlast;
                    beat_cyc[nbeats]  = cyc;
                end
                nbeats++;
                hs_total++;
                hs_since_reset++;
            end
        end else begin
            chk("rst_wvalid", 64'(m_wvalid), 64'(0));
            chk("rst_wlast", 64'(m_wlast), 64'(0));
            chk("rst_read", 64'(fifo_if.read), 64'(0));
            chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
            hs_since_reset = 0;
            hs_total       = reads_total;
        end
        pv = m_wvalid && rstn;
        pr = m_wready;
        pd = m_wdata;
        pl = m_wlast;
    end

    task automatic push_words(input int n);
        @(posedge clk);
        #1;
        wr_idx += n;
    endtask

    task automatic issue(input int len, output int acc);
        exp_t e;
        int   t;
        for (int i = 0; i <= len; i++) begin
            e.d = data_of(exp_idx + i);
            e.l = (i == len);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_len   = LW'(len);
        acc = -1;
        t   = 0;
        while (t < 50) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = cyc + 1;
                break;
            end
            t++;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (acc < 0) begin
            checks++;
            failures++;
            $display("FAIL cmd_accept_timeout: got cmd_ready=0 expected 1 within 50 cycles");
        end
        cmd_words_total += len + 1;
        exp_idx         += len + 1;
    endtask

    task automatic wait_beats(input int target, input int limit);
        int t;
        t = 0;
        while (nbeats < target && t < limit) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (nbeats < target) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: got %0d beats expected %0d", nbeats, target);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, acc, r0, t;

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("reset_wvalid", 64'(m_wvalid), 64'(0));
        chk("reset_wlast", 64'(m_wlast), 64'(0));
        chk("reset_read", 64'(fifo_if.read), 64'(0));

        // 4-beat burst, streaming
        base = nbeats;
        r0   = reads_total;
        push_words(4);
        issue(3, acc);
        wait_beats(base + 4, 40);
        chk("t1_first_beat_cyc", 64'(beat_cyc[base]), 64'(acc + 2));
        chk("t1_last_beat_cyc", 64'(beat_cyc[base + 3]), 64'(acc + 5));
        chk("t1_data_a", 64'(beat_dat[base]), 64'(32'hC0DE_0000));
        chk("t1_data_d", 64'(beat_dat[base + 3]), 64'(32'hC0DE_0003));
        chk("t1_wlast_pattern", 64'({beat_last[base + 3], beat_last[base + 2],
                                     beat_last[base + 1], beat_last[base]}), 64'(4'b1000));
        chk("t1_cmd_ready_in_burst", 64'(cmd_ready), 64'(0));
        @(negedge clk);
        chk("t1_idle_cycle", 64'(cyc), 64'(acc + 6));
        chk("t1_cmd_ready_next", 64'(cmd_ready), 64'(1));
        chk("t1_reads", 64'(reads_total - r0), 64'(4));

        // single-beat burst
        base = nbeats;
        r0   = reads_total;
        push_words(1);
        issue(0, acc);
        wait_beats(base + 1, 20);
        repeat (3) @(negedge clk);
        chk("t2_data", 64'(beat_dat[base]), 64'(32'hC0DE_0004));
        chk("t2_wlast", 64'(beat_last[base]), 64'(1));
        chk("t2_reads", 64'(reads_total - r0), 64'(1));

        // 8 beats with wready 1,0,0 back-pressure
        base    = nbeats;
        r0      = reads_total;
        wr_mode = 1;
        push_words(8);
        issue(7, acc);
        wait_beats(base + 8, 200);
        wr_mode = 0;
        repeat (2) @(negedge clk);
        chk("t3_data_last", 64'(beat_dat[base + 7]), 64'(32'hC0DE_000C));
        chk("t3_wlast", 64'(beat_last[base + 7]), 64'(1));
        chk("t3_reads", 64'(reads_total - r0), 64'(8));

        // FIFO runs dry after 2 of 5 words, refilled 10 cycles later
        base = nbeats;
        r0   = reads_total;
        push_words(2);
        issue(4, acc);
        wait_beats(base + 2, 30);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_gap_wvalid", 64'(m_wvalid), 64'(0));
        end
        push_words(3);
        wait_beats(base + 5, 30);
        repeat (2) @(negedge clk);
        chk("t4_data5", 64'(beat_dat[base + 4]), 64'(32'hC0DE_0011));
        chk("t4_wlast5", 64'(beat_last[base + 4]), 64'(1));
        chk("t4_wlast4", 64'(beat_last[base + 3]), 64'(0));
        chk("t4_reads", 64'(reads_total - r0), 64'(5));

        // 256-beat burst
        base = nbeats;
        r0   = reads_total;
        push_words(256);
        issue(255, acc);
        wait_beats(base + 256, 400);
        repeat (2) @(negedge clk);
        chk("t5_span", 64'(beat_cyc[base + 255] - beat_cyc[base]), 64'(255));
        chk("t5_data256", 64'(beat_dat[base + 255]), 64'(32'hC0DE_0111));
        chk("t5_wlast256", 64'(beat_last[base + 255]), 64'(1));
        chk("t5_wlast255", 64'(beat_last[base + 254]), 64'(0));
        chk("t5_reads", 64'(reads_total - r0), 64'(256));

        // reset for one cycle while beat 3 of 8 is handshaking
        base = nbeats;
        push_words(8);
        issue(7, acc);
        t = 0;
        while (cyc != acc + 4 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("t6_beat3_on_bus", 64'(m_wdata), 64'(data_of(exp_idx - 8 + 2)));
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(negedge clk);
        chk("t6_beats_before_rst", 64'(nbeats - base), 64'(3));
        chk("t6_rst_wvalid", 64'(m_wvalid), 64'(0));
        chk("t6_rst_read", 64'(fifo_if.read), 64'(0));
        chk("t6_rst_cmd_ready", 64'(cmd_ready), 64'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_q.delete();
        cmd_words_total = reads_total;
        @(negedge clk);
        chk("t6_post_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("t6_post_wvalid", 64'(m_wvalid), 64'(0));
        chk("t6_post_wlast", 64'(m_wlast), 64'(0));
`ifdef REDMA_W_BEAT_CNT_EN
        chk("t6_post_beat_cnt", 64'(beat_cnt), 64'(0));
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_quiet_wvalid", 64'(m_wvalid), 64'(0));
            chk("t6_quiet_read", 64'(fifo_if.read), 64'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
